layer_sched: RTL and testbench
==============================

LAYER_SCHED -- requirements
Module: layer_sched

Interface
REQ-001 Parameter CFG_DWIDTH, default 32: config data width.
REQ-002 Parameter CFG_AWIDTH, default 5: config address width.
REQ-003 Parameter CFG_ADDR, default 8: base config address; CFG_ADDR holds window/pool fields, CFG_ADDR+1 holds pixel count.
REQ-004 Parameter CNT_WIDTH, default 16: width of word and pixel counters.
REQ-005 Port clk  input  1  single clock, all state on rising edge.
REQ-006 Port rst  input  1  reset, asynchronous and active-low.
REQ-007 Ports cfg_data / cfg_addr / cfg_valid  input  CFG_DWIDTH / CFG_AWIDTH / 1  shared config write bus.
REQ-008 Port start  input  1  one-cycle request to begin a layer pass.
REQ-009 Ports src_val input 1, src_rdy output 1  upstream image-word handshake; data bypasses this block.
REQ-010 Ports image_val output 1, image_last output 1, image_rdy input 1  handshake to the layers datapath.
REQ-011 Ports res_val input 1, res_rdy input 1  observed datapath result handshake; a result is taken when both are high.
REQ-012 Ports busy output 1, done output 1  status; done is a one-cycle pulse.

Function
REQ-013 A cfg write at CFG_ADDR SHALL latch win_len=cfg_data[15:0] and pool_nb=cfg_data[23:16]; a write at CFG_ADDR+1 SHALL latch px_nb=cfg_data[15:0]; writes SHALL be ignored while busy=1.
REQ-014 win_len=0 SHALL be treated as 1.
REQ-015 FSM states: IDLE, RUN, DRAIN, DONE; one-hot encoding.
REQ-016 IDLE: start=1 -> RUN with all counters cleared; if px_nb=0, go to DONE instead.
REQ-017 In RUN, image_val=src_val and src_rdy=image_rdy, both combinational; outside RUN both SHALL be 0.
REQ-018 A word is transferred when image_val&image_rdy; word_cnt increments per transfer.
REQ-019 image_last SHALL be 1 exactly when word_cnt==win_len-1 in RUN.
REQ-020 On a last-word transfer: word_cnt wraps to 0 and win_cnt increments; when win_cnt==pool_nb, win_cnt wraps to 0 and px_cnt increments.
REQ-021 When the transfer completes pixel px_nb-1, the FSM SHALL go RUN -> DRAIN in the next cycle.
REQ-022 out_cnt SHALL increment on each res_val&res_rdy in RUN or DRAIN.
REQ-023 DRAIN -> DONE when out_cnt==px_nb, including when the final increment and the DRAIN entry occur in the same cycle.
REQ-024 DONE lasts exactly one cycle with done=1, then -> IDLE.
REQ-025 busy=1 in RUN, DRAIN and DONE.
REQ-026 start is ignored outside IDLE.
REQ-027 Counters SHALL wrap modulo 2^CNT_WIDTH and SHALL never exceed configured limits in normal operation.

Reset
REQ-028 rst low SHALL force IDLE immediately, asynchronously; busy, done, image_val, image_last and src_rdy go to 0; all counters go to 0.
REQ-029 Config registers SHALL reset to win_len=1, pool_nb=0, px_nb=0.
REQ-030 Reset mid-pass SHALL abandon the pass with no done pulse.

Configuration
REQ-031 Macro LAYER_SCHED_ABORT_EN defined: adds input port abort (1 bit).
REQ-032 With the macro, abort=1 in RUN or DRAIN SHALL return the FSM to IDLE next cycle, clear counters, emit no done, and drop image_val/src_rdy the same cycle combinationally.
REQ-033 Without the macro, the abort port and its logic are absent, and the FSM is as in REQ-015..REQ-027.

Verification
REQ-034 win_len=4, pool_nb=0, px_nb=2, src_val and image_rdy held 1, start -> 8 transfers; image_last on transfers 4 and 8; DRAIN; after 2 results, done pulse once, busy=0.
REQ-035 win_len=3, pool_nb=3, px_nb=1, image_rdy toggling every cycle -> exactly 12 transfers, 4 image_last; no transfer while image_rdy=0.
REQ-036 px_nb=0, start -> done one cycle later; image_val never 1.
REQ-037 Config write and start during RUN -> ignored; the pass completes with the original win_len/px_nb.
REQ-038 rst low after 5 transfers -> immediately IDLE, busy=0, no done; the next start restarts from count 0.
REQ-039 With LAYER_SCHED_ABORT_EN, abort in DRAIN -> IDLE next cycle, no done; a following pass completes normally.

Source files
------------

// File: rtl/layer_sched_if.sv
// Bus bundle for layer_sched: shared config write port, upstream image-word
// handshake, layers-datapath handshake and observed result handshake.
interface layer_sched_if #(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned CFG_AWIDTH = 5
);
    logic [CFG_DWIDTH-1:0] cfg_data;
    logic [CFG_AWIDTH-1:0] cfg_addr;
    logic                  cfg_valid;
    logic                  src_val;
    logic                  src_rdy;
    logic                  image_val;
    logic                  image_last;
    logic                  image_rdy;
    logic                  res_val;
    logic                  res_rdy;

    // Environment side: drives config, upstream valid, datapath ready and results.
    modport master (
        output cfg_data, cfg_addr, cfg_valid,
        output src_val, image_rdy, res_val, res_rdy,
        input  src_rdy, image_val, image_last
    );

    // Scheduler side.
    modport slave (
        input  cfg_data, cfg_addr, cfg_valid,
        input  src_val, image_rdy, res_val, res_rdy,
        output src_rdy, image_val, image_last
    );
endinterface

// File: rtl/layer_sched.sv
// layer_sched: sequences one layer pass over px_nb pixels, each pixel made of
// (pool_nb+1) windows of win_len image words, then waits for px_nb results.
// Image data itself bypasses this block; only the handshakes are gated here.
// Optional feature: define LAYER_SCHED_ABORT_EN to add an abort input that
// cancels a pass in RUN or DRAIN without a done pulse.
module layer_sched #(
    parameter int unsigned CFG_DWIDTH = 32,
    parameter int unsigned CFG_AWIDTH = 5,
    parameter int unsigned CFG_ADDR   = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
`ifdef LAYER_SCHED_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    layer_sched_if.slave bus
);

    localparam int unsigned WIN_W  = 16;
    localparam int unsigned POOL_W = 8;
    localparam int unsigned PX_W   = 16;

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RUN   = 4'b0010,
        DRAIN = 4'b0100,
        DONE  = 4'b1000
    } state_e;

    state_e               state_q,    state_d;
    logic [WIN_W-1:0]     win_len_q,  win_len_d;
    logic [POOL_W-1:0]    pool_nb_q,  pool_nb_d;
    logic [PX_W-1:0]      px_nb_q,    px_nb_d;
    logic [CNT_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [CNT_WIDTH-1:0] win_cnt_q,  win_cnt_d;
    logic [CNT_WIDTH-1:0] px_cnt_q,   px_cnt_d;
    logic [CNT_WIDTH-1:0] out_cnt_q,  out_cnt_d;

    logic                 run_open_c;
    logic                 xfer_c;
    logic                 res_fire_c;
    logic                 last_word_c;
    logic                 last_win_c;
    logic                 last_px_c;
    logic                 out_full_c;
    logic [WIN_W-1:0]     win_len_eff_c;

    // The handshake pass-through is open only in RUN (and, when enabled, not while aborting).
`ifdef LAYER_SCHED_ABORT_EN
    assign run_open_c = (state_q == RUN) && !abort;
`else
    assign run_open_c = (state_q == RUN);
`endif

    // Combinational handshake gating and position decode.
    assign bus.image_val  = run_open_c && bus.src_val;
    assign bus.src_rdy    = run_open_c && bus.image_rdy;
    assign xfer_c         = bus.image_val && bus.image_rdy;
    assign res_fire_c     = bus.res_val && bus.res_rdy;
    assign win_len_eff_c  = (win_len_q == '0) ? WIN_W'(1) : win_len_q;
    assign last_word_c    = (word_cnt_q == CNT_WIDTH'(win_len_eff_c - WIN_W'(1)));
    assign last_win_c     = (win_cnt_q == CNT_WIDTH'(pool_nb_q));
    assign last_px_c      = (px_cnt_q == CNT_WIDTH'(px_nb_q - PX_W'(1)));
    assign out_full_c     = (out_cnt_q == CNT_WIDTH'(px_nb_q));
    assign bus.image_last = (state_q == RUN) && last_word_c;

    // Status decodes straight from the one-hot state register.
    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);

    // Config register writes, accepted only while idle.
    always_comb begin
        win_len_d = win_len_q;
        pool_nb_d = pool_nb_q;
        px_nb_d   = px_nb_q;
        if (bus.cfg_valid && (state_q == IDLE)) begin
            if (bus.cfg_addr == CFG_AWIDTH'(CFG_ADDR)) begin
                win_len_d = bus.cfg_data[15:0];
                pool_nb_d = bus.cfg_data[23:16];
            end else if (bus.cfg_addr == CFG_AWIDTH'(CFG_ADDR + 1)) begin
                px_nb_d = bus.cfg_data[15:0];
            end
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        win_cnt_d  = win_cnt_q;
        px_cnt_d   = px_cnt_q;
        out_cnt_d  = out_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    word_cnt_d = '0;
                    win_cnt_d  = '0;
                    px_cnt_d   = '0;
                    out_cnt_d  = '0;
                    state_d    = (px_nb_q == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer_c) begin
                    if (last_word_c) begin
                        word_cnt_d = '0;
                        if (last_win_c) begin
                            win_cnt_d = '0;
                            px_cnt_d  = px_cnt_q + CNT_WIDTH'(1);
                            if (last_px_c) begin
                                state_d = DRAIN;
                            end
                        end else begin
                            win_cnt_d = win_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        word_cnt_d = word_cnt_q + CNT_WIDTH'(1);
                    end
                end
                // Results beyond px_nb are not counted so out_cnt stays within its limit.
                if (res_fire_c && !out_full_c) begin
                    out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (res_fire_c && !out_full_c) begin
                    out_cnt_d = out_cnt_q + CNT_WIDTH'(1);
                end
                // out_cnt may already be full on entry when the last result
                // arrived together with the last word.
                if (out_full_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

`ifdef LAYER_SCHED_ABORT_EN
        // Abort cancels the pass without passing through DONE.
        if (abort && ((state_q == RUN) || (state_q == DRAIN))) begin
            state_d    = IDLE;
            word_cnt_d = '0;
            win_cnt_d  = '0;
            px_cnt_d   = '0;
            out_cnt_d  = '0;
        end
`endif
    end

    // State, counter and config registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            win_len_q  <= WIN_W'(1);
            pool_nb_q  <= '0;
            px_nb_q    <= '0;
            word_cnt_q <= '0;
            win_cnt_q  <= '0;
            px_cnt_q   <= '0;
            out_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            win_len_q  <= win_len_d;
            pool_nb_q  <= pool_nb_d;
            px_nb_q    <= px_nb_d;
            word_cnt_q <= word_cnt_d;
            win_cnt_q  <= win_cnt_d;
            px_cnt_q   <= px_cnt_d;
            out_cnt_q  <= out_cnt_d;
        end
    end

endmodule

// File: tb/tb_layer_sched.sv
// Directed bench for layer_sched: hand-computed expectations for transfer
// counts, image_last positions, done pulses and reset/abort behaviour.
module tb_layer_sched;

    logic clk;
    logic rst;
    logic start;
    logic busy;
    logic done;
`ifdef LAYER_SCHED_ABORT_EN
    logic abort;
`endif

    int checks;
    int failures;

    // Monitor tallies, only ever incremented; steps take deltas.
    int n_xfer;
    int n_last;
    int n_done;
    int n_val;
    int n_bad;

    int b_xfer;
    int b_last;
    int b_done;
    int b_val;
    int b_bad;

    layer_sched_if #(.CFG_DWIDTH(32), .CFG_AWIDTH(5)) bus ();

    layer_sched #(
        .CFG_DWIDTH(32),
        .CFG_AWIDTH(5),
        .CFG_ADDR  (8),
        .CNT_WIDTH (16)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
`ifdef LAYER_SCHED_ABORT_EN
        .abort(abort),
`endif
        .busy (busy),
        .done (done),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count handshake events mid-cycle, where inputs and outputs are stable.
    always @(negedge clk) begin
        if (bus.image_val && bus.image_rdy) begin
            n_xfer <= n_xfer + 1;
            if (bus.image_last) n_last <= n_last + 1;
        end
        if (done)                          n_done <= n_done + 1;
        if (bus.image_val)                 n_val  <= n_val + 1;
        if (bus.src_rdy && !bus.image_rdy) n_bad  <= n_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_xfer = n_xfer;
        b_last = n_last;
        b_done = n_done;
        b_val  = n_val;
        b_bad  = n_bad;
    endtask

    task automatic cfg_write(input logic [4:0] addr, input logic [31:0] data);
        bus.cfg_addr  = addr;
        bus.cfg_data  = data;
        bus.cfg_valid = 1'b1;
        tick();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic res_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            bus.res_val = 1'b1;
            bus.res_rdy = 1'b1;
            tick();
        end
        bus.res_val = 1'b0;
        bus.res_rdy = 1'b0;
    endtask

    initial begin
        checks = 0;   failures = 0;
        n_xfer = 0;   n_last = 0; n_done = 0; n_val = 0; n_bad = 0;
        rst = 1'b0;   start = 1'b0;
`ifdef LAYER_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        bus.cfg_data = '0; bus.cfg_addr = '0; bus.cfg_valid = 1'b0;
        bus.src_val = 1'b1; bus.image_rdy = 1'b1;
        bus.res_val = 1'b0; bus.res_rdy = 1'b0;

        // Reset: outputs quiet even with upstream valid and ready asserted.
        tick(); tick();
        chk("rst_busy",      busy,           1'b0);
        chk("rst_done",      done,           1'b0);
        chk("rst_image_val", bus.image_val,  1'b0);
        chk("rst_src_rdy",   bus.src_rdy,    1'b0);
        chk("rst_last",      bus.image_last, 1'b0);
        rst = 1'b1;
        tick();

        // Default px_nb=0: done the cycle after start, no image traffic.
        snap();
        pulse_start();
        chk("px0_done",  done, 1'b1);
        chk("px0_busy",  busy, 1'b1);
        tick();
        chk("px0_done_off", done, 1'b0);
        chk("px0_idle",     busy, 1'b0);
        chk("px0_no_val",   32'(n_val - b_val), 32'd0);

        // win_len=0 behaves as 1: every word is a last word.
        cfg_write(5'd8, 32'h0000_0000);
        cfg_write(5'd9, 32'h0000_0002);
        snap();
        pulse_start();
        for (int i = 0; i < 2; i++) begin
            chk("w0_last", bus.image_last, 1'b1);
            tick();
        end
        chk("w0_drain_val", bus.image_val, 1'b0);
        res_pulses(2);
        for (int i = 0; i < 4; i++) tick();
        chk("w0_xfer", 32'(n_xfer - b_xfer), 32'd2);
        chk("w0_last_n", 32'(n_last - b_last), 32'd2);
        chk("w0_done_n", 32'(n_done - b_done), 32'd1);

        // win_len=4, pool_nb=0, px_nb=2, continuous flow.
        cfg_write(5'd8, 32'h0000_0004);
        cfg_write(5'd9, 32'h0000_0002);
        snap();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            chk("p34_val",  bus.image_val,  1'b1);
            chk("p34_last", bus.image_last, ((i == 3) || (i == 7)) ? 1'b1 : 1'b0);
            tick();
        end
        chk("p34_drain_val",  bus.image_val, 1'b0);
        chk("p34_drain_rdy",  bus.src_rdy,   1'b0);
        chk("p34_drain_busy", busy,          1'b1);
        chk("p34_xfer",   32'(n_xfer - b_xfer), 32'd8);
        chk("p34_last_n", 32'(n_last - b_last), 32'd2);
        chk("p34_no_done", 32'(n_done - b_done), 32'd0);
        res_pulses(2);
        for (int i = 0; i < 6; i++) tick();
        chk("p34_done_n", 32'(n_done - b_done), 32'd1);
        chk("p34_idle",   busy, 1'b0);

        // win_len=3, pool_nb=3, px_nb=1, image_rdy toggling; result arrives early.
        cfg_write(5'd8, 32'h0003_0003);
        cfg_write(5'd9, 32'h0000_0001);
        snap();
        bus.res_val = 1'b1; bus.res_rdy = 1'b1;
        pulse_start();
        for (int i = 0; i < 40; i++) begin
            bus.image_rdy = ~bus.image_rdy;
            tick();
        end
        bus.image_rdy = 1'b1;
        bus.res_val = 1'b0; bus.res_rdy = 1'b0;
        chk("p35_xfer",   32'(n_xfer - b_xfer), 32'd12);
        chk("p35_last_n", 32'(n_last - b_last), 32'd4);
        chk("p35_gate",   32'(n_bad - b_bad),   32'd0);
        chk("p35_done_n", 32'(n_done - b_done), 32'd1);
        chk("p35_idle",   busy, 1'b0);

        // Config write and start during RUN are ignored.
        cfg_write(5'd8, 32'h0000_0004);
        cfg_write(5'd9, 32'h0000_0001);
        snap();
        pulse_start();
        tick(); tick();
        bus.cfg_addr = 5'd8; bus.cfg_data = 32'h0000_0002; bus.cfg_valid = 1'b1;
        start = 1'b1;
        tick();
        bus.cfg_addr = 5'd9; bus.cfg_data = 32'h0000_0005;
        tick();
        bus.cfg_valid = 1'b0; start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("p37_xfer",    32'(n_xfer - b_xfer), 32'd4);
        chk("p37_last_n",  32'(n_last - b_last), 32'd1);
        chk("p37_drain",   busy, 1'b1);
        chk("p37_no_done", 32'(n_done - b_done), 32'd0);
        res_pulses(1);
        for (int i = 0; i < 4; i++) tick();
        chk("p37_done_n", 32'(n_done - b_done), 32'd1);
        chk("p37_idle",   busy, 1'b0);

        // Reset mid-pass after 5 transfers, then restart from count 0.
        cfg_write(5'd9, 32'h0000_0002);
        snap();
        pulse_start();
        for (int i = 0; i < 5; i++) tick();
        chk("p38_xfer5", 32'(n_xfer - b_xfer), 32'd5);
        rst = 1'b0;
        #1;
        chk("p38_busy",  busy,           1'b0);
        chk("p38_val",   bus.image_val,  1'b0);
        chk("p38_rdy",   bus.src_rdy,    1'b0);
        chk("p38_last",  bus.image_last, 1'b0);
        tick();
        rst = 1'b1;
        tick();
        chk("p38_no_done", 32'(n_done - b_done), 32'd0);
        cfg_write(5'd8, 32'h0000_0004);
        cfg_write(5'd9, 32'h0000_0002);
        snap();
        pulse_start();
        for (int i = 0; i < 8; i++) begin
            chk("p38_re_last", bus.image_last, ((i == 3) || (i == 7)) ? 1'b1 : 1'b0);
            tick();
        end
        res_pulses(2);
        for (int i = 0; i < 6; i++) tick();
        chk("p38_re_xfer",   32'(n_xfer - b_xfer), 32'd8);
        chk("p38_re_done_n", 32'(n_done - b_done), 32'd1);

`ifdef LAYER_SCHED_ABORT_EN
        // Abort in DRAIN: back to IDLE with no done, then a clean pass.
        cfg_write(5'd8, 32'h0000_0001);
        cfg_write(5'd9, 32'h0000_0001);
        snap();
        pulse_start();
        tick();
        chk("p39_drain", busy, 1'b1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("p39_idle", busy, 1'b0);
        for (int i = 0; i < 3; i++) tick();
        chk("p39_no_done", 32'(n_done - b_done), 32'd0);
        snap();
        pulse_start();
        tick();
        res_pulses(1);
        for (int i = 0; i < 4; i++) tick();
        chk("p39_xfer",   32'(n_xfer - b_xfer), 32'd1);
        chk("p39_done_n", 32'(n_done - b_done), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
